// File: rtl/bcd2b_pkg.sv
// ----------------------------------------------------------------------------
// bcd2b_pkg : shared state encoding, default sizes and digit-check helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bcd2b_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } state_e;

   localparam int c_NDIG_DEF = 4;
   localparam int c_BW_DEF   = 14;

   function automatic logic digit_bad(input logic [3:0] d);
      return (d > 4'd9);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd2b_bcd_adj.sv
// ----------------------------------------------------------------------------
// bcd_adj : reverse double-dabble digit correction (subtract 3 when >= 8)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_adj (
   input  logic [3:0] in_i,
   output logic [3:0] out_o
);

   assign out_o = in_i[3] ? (in_i - 4'd3) : in_i;

endmodule

`default_nettype wire

// File: rtl/bcd2b.sv
// ----------------------------------------------------------------------------
// bcd2b : sequential BCD-to-binary converter, one result bit per clock
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bcd2b
   import bcd2b_pkg::*;
#(
   parameter int NDIG = c_NDIG_DEF,
   parameter int BW   = c_BW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [3:0]    bcd3,
   input  logic [3:0]    bcd2,
   input  logic [3:0]    bcd1,
   input  logic [3:0]    bcd0,
   output logic [BW-1:0] bin,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int DW = 4 * NDIG;
   localparam int CW = $clog2(BW + 1);
   localparam logic [CW-1:0] c_CNT_LAST = CW'(BW);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [DW-1:0]   dig_q,   dig_d;
   logic [BW-1:0]   shd_q,   shd_d;
   logic [BW-1:0]   bin_q,   bin_d;
   logic            done_q,  done_d;
   logic            err_q,   err_d;

   logic [3:0]      w_port_dig [4];
   logic [DW-1:0]   w_load;
   logic [NDIG-1:0] w_bad;
   logic            w_any_bad;
   logic [DW-1:0]   w_shift;
   logic [DW-1:0]   w_adj;
   logic [BW-1:0]   w_shd_next;
   logic [CW-1:0]   w_cnt_inc;

   assign w_port_dig[0] = bcd0;
   assign w_port_dig[1] = bcd1;
   assign w_port_dig[2] = bcd2;
   assign w_port_dig[3] = bcd3;

   // Digits beyond the four physical ports load as zero.
   for (genvar i = 0; i < NDIG; i++) begin : g_load
      if (i < 4) begin : g_port
         assign w_load[4*i +: 4] = w_port_dig[i];
         assign w_bad[i]         = digit_bad(w_port_dig[i]);
      end else begin : g_pad
         assign w_load[4*i +: 4] = 4'd0;
         assign w_bad[i]         = 1'b0;
      end
   end

   assign w_any_bad  = |w_bad;
   assign w_shift    = dig_q >> 1;
   assign w_shd_next = {dig_q[0], shd_q[BW-1:1]};
   assign w_cnt_inc  = cnt_q + 1'b1;

   for (genvar i = 0; i < NDIG; i++) begin : g_adj
      bcd_adj u_adj (
         .in_i  (w_shift[4*i +: 4]),
         .out_o (w_adj[4*i +: 4])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dig_d   = dig_q;
      shd_d   = shd_q;
      bin_d   = bin_q;
      err_d   = err_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (w_any_bad) begin
                  err_d  = 1'b1;
                  bin_d  = '0;
                  done_d = 1'b1;
               end else begin
                  dig_d   = w_load;
                  shd_d   = '0;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  state_d = CONVERT;
               end
            end
         end
         CONVERT: begin
            dig_d = w_adj;
            shd_d = w_shd_next;
            cnt_d = w_cnt_inc;
            if (w_cnt_inc == c_CNT_LAST) begin
               state_d = IDLE;
               bin_d   = w_shd_next;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dig_q   <= '0;
         shd_q   <= '0;
         bin_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         shd_q   <= shd_d;
         bin_q   <= bin_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bin  = bin_q;
   assign busy = (state_q == CONVERT);
   assign done = done_q;
   assign err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd2b.sv
// ----------------------------------------------------------------------------
// tb_bcd2b : directed self-checking bench for bcd2b
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bcd2b;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  bcd3, bcd2, bcd1, bcd0;
   logic [13:0] bin;
   logic        busy, done, err;

   int n_chk;
   int n_err;

   bcd2b #(.NDIG(4), .BW(14)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bcd3  (bcd3),
      .bcd2  (bcd2),
      .bcd1  (bcd1),
      .bcd0  (bcd0),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
      bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
   endtask

   // Pulse start for one edge, then follow the conversion to its done pulse.
   task automatic run_conv(input string tag, input logic [3:0] d3, d2, d1, d0,
                           input int exp_bin, input bit disturb);
      int edges;
      int busy_cnt;
      @(negedge clk);
      set_digits(d3, d2, d1, d0);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      edges    = 1;
      busy_cnt = 0;
      @(negedge clk);
      while (!done && edges < 40) begin
         busy_cnt += int'(busy);
         if (disturb) begin
            start = 1'($urandom_range(0, 1));
            set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         end
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, " edges"}, edges, 15);
      chk({tag, " busy cycles"}, busy_cnt, 14);
      chk({tag, " done"}, int'(done), 1);
      chk({tag, " bin"}, int'(bin), exp_bin);
      chk({tag, " err"}, int'(err), 0);
      chk({tag, " busy at done"}, int'(busy), 0);
      @(negedge clk);
      chk({tag, " single done"}, int'(done), 0);
      chk({tag, " bin hold"}, int'(bin), exp_bin);
   endtask

   initial begin
      int last_done;
      int pulses;
      int cyc;
      int guard;
      n_chk = 0;
      n_err = 0;
      start = 1'b0;
      set_digits(4'd0, 4'd0, 4'd0, 4'd0);
      reset = 1'b0;
      #3;
      chk("reset bin", int'(bin), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset err", int'(err), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      run_conv("zero", 4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b0);
      run_conv("1234", 4'd1, 4'd2, 4'd3, 4'd4, 1234, 1'b0);
      run_conv("9999", 4'd9, 4'd9, 4'd9, 4'd9, 9999, 1'b0);
      run_conv("9001", 4'd9, 4'd0, 4'd0, 4'd1, 9001, 1'b0);

      // Invalid digit: immediate done with err, no conversion.
      @(negedge clk);
      set_digits(4'd1, 4'd2, 4'hA, 4'd4);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("bad done", int'(done), 1);
      chk("bad err", int'(err), 1);
      chk("bad bin", int'(bin), 0);
      chk("bad busy", int'(busy), 0);
      @(negedge clk);
      chk("bad done once", int'(done), 0);
      chk("bad busy after", int'(busy), 0);
      chk("bad err held", int'(err), 1);
      run_conv("42", 4'd0, 4'd0, 4'd4, 4'd2, 42, 1'b0);

      run_conv("5678 disturbed", 4'd5, 4'd6, 4'd7, 4'd8, 5678, 1'b1);

      // Asynchronous reset part-way through a conversion.
      run_conv("42 again", 4'd0, 4'd0, 4'd4, 4'd2, 42, 1'b0);
      @(negedge clk);
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (6) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort busy", int'(busy), 0);
      chk("abort done", int'(done), 0);
      chk("abort bin", int'(bin), 0);
      chk("abort err", int'(err), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort no done", int'(done), 0);
      end
      reset = 1'b1;
      run_conv("100 after reset", 4'd0, 4'd1, 4'd0, 4'd0, 100, 1'b0);

      // Start held high: one result every 15 cycles.
      @(negedge clk);
      set_digits(4'd0, 4'd0, 4'd1, 4'd0);
      start     = 1'b1;
      last_done = -1;
      pulses    = 0;
      for (cyc = 1; cyc <= 50; cyc++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            chk("b2b bin", int'(bin), 10);
            if (last_done < 0) chk("b2b first latency", cyc, 15);
            else               chk("b2b period", cyc - last_done, 15);
            last_done = cyc;
         end
      end
      chk("b2b pulses", pulses, 3);
      start = 1'b0;
      guard = 0;
      while (busy && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      chk("b2b drain", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
